// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshake, status flags and an
//            optional iterative shift-add multiplier (macro ALU_PIPE_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    logic [WIDTH-1:0] r_result;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_out_valid;
    logic             r_ready_en;

    logic             w_accept;
    logic             w_idle;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_lo;
    logic             w_mul_c;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;

    // r_ready_en keeps in_ready low while reset is held and until the first edge after release
    assign in_ready = r_ready_en && w_idle && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_OR:  w_res = a | b;
            c_OP_NOT: w_res = ~a;
            c_OP_SHL: w_res = a << b[SHAMT_W-1:0];
            // Reached only without the multiplier: flag the illegal op via carry
            default:  w_c   = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam logic [1:0]         c_ST_IDLE  = 2'd0;
    localparam logic [1:0]         c_ST_MUL   = 2'd1;
    localparam logic [1:0]         c_ST_DONE  = 2'd2;
    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_busy;
    logic [WIDTH:0]     w_mul_sum;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = c_ST_MUL;
            c_ST_MUL:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Accumulator holds {partial product, unconsumed multiplier bits}; shifts right each step
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (r_state == c_ST_IDLE && w_accept && w_is_mul) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == c_ST_MUL) begin
            r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
        end else if (r_state == c_ST_DONE) begin
            r_busy  <= 1'b0;
        end
    end

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_is_mul   = (op == c_OP_MUL);
    assign w_mul_done = (r_state == c_ST_DONE);
    assign w_mul_lo   = r_acc[WIDTH-1:0];
    assign w_mul_c    = |r_acc[2*WIDTH-1:WIDTH];
    assign busy       = r_busy;
`else
    assign w_idle     = 1'b1;
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_lo   = '0;
    assign w_mul_c    = 1'b0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en  <= 1'b0;
            r_result    <= '0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept && !w_is_mul) begin
                r_result    <= w_res;
                r_flag_c    <= w_c;
                r_flag_v    <= w_v;
                r_out_valid <= 1'b1;
            end else if (w_mul_done) begin
                r_result    <= w_mul_lo;
                r_flag_c    <= w_mul_c;
                r_flag_v    <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    // Z and N derive from the held result, so they stay stable under back-pressure too
    assign flag_z    = r_ready_en && (r_result == '0);
    assign flag_n    = r_result[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe (WIDTH=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flag_c;
    logic        flag_v;
    logic        flag_z;
    logic        flag_n;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;

    alu_pipe #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_cvzn);
        check(tag, {60'd0, flag_c, flag_v, flag_z, flag_n}, {60'd0, exp_cvzn});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {56'd0, in_ready, out_valid, flag_c, flag_v, flag_z, flag_n, busy, 1'b0}, 64'd0);
        check({tag, "_result"}, result, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        a         = '0;
        b         = '0;

        // Reset at power-up
        repeat (3) tick();
        check_all_zero("reset_initial");
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", {63'd0, in_ready}, 64'd1);
        check("no_valid_after_reset", {63'd0, out_valid}, 64'd0);

        // Add with signed overflow
        op = 3'b000; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_ovf_valid", {63'd0, out_valid}, 64'd1);
        check("add_ovf_result", result, 64'h8000_0000_0000_0000);
        check_flags("add_ovf_cvzn", 4'b0101);

        // Add with carry out, zero result
        op = 3'b000; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; in_valid = 1'b1;
        tick();
        check("add_carry_result", result, 64'd0);
        check_flags("add_carry_cvzn", 4'b1010);

        // Sub with borrow
        op = 3'b001; a = 64'd5; b = 64'd7;
        tick();
        check("sub_borrow_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_flags("sub_borrow_cvzn", 4'b1001);

        // Sub to zero
        a = 64'd9; b = 64'd9;
        tick();
        check("sub_zero_result", result, 64'd0);
        check_flags("sub_zero_cvzn", 4'b0010);

        // Sub with signed overflow: min - 1
        a = 64'h8000_0000_0000_0000; b = 64'd1;
        tick();
        check("sub_ovf_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
        check_flags("sub_ovf_cvzn", 4'b0100);

        // Logic ops
        op = 3'b010; a = 64'hF0F0; b = 64'h0FF0;
        tick();
        check("and_result", result, 64'h00F0);
        op = 3'b100; a = 64'hF0; b = 64'h0F;
        tick();
        check("or_result", result, 64'hFF);
        op = 3'b101; a = 64'd0; b = 64'h1234;
        tick();
        check("not_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check_flags("not_cvzn", 4'b0001);
        // Only the low 6 bits of b select the shift: 0x41 -> shift by 1
        op = 3'b110; a = 64'd3; b = 64'h41;
        tick();
        check("shl_mask_result", result, 64'd6);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // Back-pressure: three ops offered back-to-back while the consumer stalls
        out_ready = 1'b0;
        op = 3'b000; a = 64'd1; b = 64'd2; in_valid = 1'b1;
        tick();
        op = 3'b011; a = 64'hF0; b = 64'hFF;
        for (int i = 0; i < 3; i++) begin
            check("stall_result", result, 64'd3);
            check("stall_ready", {63'd0, in_ready}, 64'd0);
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            tick();
        end
        check("stall_result_last", result, 64'd3);
        out_ready = 1'b1;
        #1;
        check("drain_accept_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("stream_xor", result, 64'h0F);
        check("stream_xor_valid", {63'd0, out_valid}, 64'd1);
        op = 3'b110; a = 64'd1; b = 64'd63;
        tick();
        in_valid = 1'b0;
        check("stream_shl", result, 64'h8000_0000_0000_0000);
        check("stream_shl_valid", {63'd0, out_valid}, 64'd1);
        tick();
        check("stream_no_dup", {63'd0, out_valid}, 64'd0);

`ifdef ALU_PIPE_MUL_EN
        // Iterative multiply: latency WIDTH+1
        op = 3'b111; a = 64'h1_0000_0000; b = 64'h1_0000_0003; in_valid = 1'b1;
        tick();
        a = '0; b = '0;
        lat = 1;
        check("mul_busy", {63'd0, busy}, 64'd1);
        check("mul_ready_low", {63'd0, in_ready}, 64'd0);
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("mul_latency", 64'(lat), 64'd65);
        check("mul_result", result, 64'h3_0000_0000);
        check_flags("mul_cvzn", 4'b1000);
        check("mul_busy_done", {63'd0, busy}, 64'd0);
        tick();

        // Reset during a second multiply
        op = 3'b111; a = 64'd7; b = 64'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("mul_reset_async");
        tick();
        rst_n = 1'b1;
        tick();
        check("mul_reset_ready", {63'd0, in_ready}, 64'd1);
        check("mul_reset_valid", {63'd0, out_valid}, 64'd0);
`else
        // Op 111 without the multiplier: single-cycle illegal-op indication
        op = 3'b111; a = 64'd3; b = 64'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("illegal_valid", {63'd0, out_valid}, 64'd1);
        check("illegal_result", result, 64'd0);
        check_flags("illegal_cvzn", 4'b1010);
        check("illegal_busy", {63'd0, busy}, 64'd0);
        tick();
`endif

        // Reset mid-traffic with a stalled result pending
        out_ready = 1'b0;
        op = 3'b000; a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; in_valid = 1'b1;
        tick();
        check("pre_reset_result", result, 64'd0);
        check_flags("pre_reset_cvzn", 4'b1110);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (3) tick();
        check_all_zero("reset_held");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
        check("ready_after_rerelease", {63'd0, in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
